// File: rtl/entropy_collector_256.sv
// Entropy collector: gathers OUT_W raw TRNG bits per run request, with a repetition-count health test.
// Optional von Neumann debiasing between the health test and the shift register: define ENT_VN_DEBIAS_EN.
module entropy_collector_256 #(
    parameter int OUT_W      = 256,
    parameter int RCT_CUTOFF = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             ent_bit_i,
    input  logic             ent_vld_i,
    output logic             busy_o,
    output logic             dvld_o,
    output logic [OUT_W-1:0] dout_o,
    output logic             err_o
);
    localparam int               CNT_W    = $clog2(OUT_W) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUT_W);
    localparam logic [7:0]       RCT_LIM  = 8'(RCT_CUTOFF);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [OUT_W-1:0] r_shift;
    logic [OUT_W-1:0] r_dout;
    logic [7:0]       r_run_len;
    logic             r_prev_bit;
    logic             r_err;

    logic             w_start;
    logic             w_raw_vld;
    logic [7:0]       w_run_len_next;
    logic             w_rct_fail;
    logic             w_col_vld;
    logic             w_col_bit;
    logic [CNT_W-1:0] w_bit_cnt_next;
    logic [OUT_W-1:0] w_shift_next;
    logic             w_full;

    assign w_start   = (r_state == S_IDLE) && run_i;
    assign w_raw_vld = (r_state == S_COLLECT) && ent_vld_i;

    // Run length restarts at 1 after a clear (r_run_len == 0) or on a bit change.
    always_comb begin
        w_run_len_next = 8'd1;
        if ((r_run_len != 8'd0) && (ent_bit_i == r_prev_bit) && (r_run_len != 8'hFF)) begin
            w_run_len_next = r_run_len + 8'd1;
        end else if ((r_run_len == 8'hFF) && (ent_bit_i == r_prev_bit)) begin
            w_run_len_next = r_run_len;
        end
        w_rct_fail = w_raw_vld && (w_run_len_next == RCT_LIM);
    end

`ifdef ENT_VN_DEBIAS_EN
    logic r_pair_have;
    logic r_pair_bit;

    // A differing pair yields its first bit: 01 -> 0, 10 -> 1.
    always_comb begin
        w_col_vld = w_raw_vld && !w_rct_fail && r_pair_have && (ent_bit_i != r_pair_bit);
        w_col_bit = r_pair_bit;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || w_start || w_rct_fail) begin
            r_pair_have <= 1'b0;
            r_pair_bit  <= 1'b0;
        end else if (w_raw_vld) begin
            r_pair_have <= ~r_pair_have;
            if (!r_pair_have) begin
                r_pair_bit <= ent_bit_i;
            end
        end
    end
`else
    always_comb begin
        w_col_vld = w_raw_vld && !w_rct_fail;
        w_col_bit = ent_bit_i;
    end
`endif

    always_comb begin
        w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
        w_shift_next   = {r_shift[OUT_W-2:0], w_col_bit};
        w_full         = w_col_vld && (w_bit_cnt_next == FULL_CNT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (run_i) w_state_next = S_COLLECT;
            S_COLLECT: if (w_full) w_state_next = S_DONE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_dout     <= '0;
            r_run_len  <= 8'd0;
            r_prev_bit <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_start) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_run_len <= 8'd0;
            r_err     <= 1'b0;
        end else if (w_rct_fail) begin
            // The failing bit is dropped and collection restarts from an empty word.
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_run_len <= 8'd0;
            r_err     <= 1'b1;
        end else if (w_raw_vld) begin
            r_run_len  <= w_run_len_next;
            r_prev_bit <= ent_bit_i;
            if (w_col_vld) begin
                r_bit_cnt <= w_bit_cnt_next;
                r_shift   <= w_shift_next;
                if (w_full) begin
                    r_dout <= w_shift_next;
                end
            end
        end
    end

    assign busy_o = (r_state != S_IDLE);
    assign dvld_o = (r_state == S_DONE);
    assign dout_o = r_dout;
    assign err_o  = r_err;

endmodule
